multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Multicycle sequencer for the 4-bit-PC MIPS subset core. Drives the 3-bit state bus seen by
//  InstructionMemory (fetch when state==0), owns the PC, and issues per-state datapath strobes.
//  Decodes lw/addiu/addu/slt/beq/bne, resolves branches, and halts at end of program or on an illegal opcode.
// PARAMETERS
//  PROG_LEN  11  number of valid instruction words; PC >= PROG_LEN ends the program
//  PC_W      4   PC width in words (word-addressed)
// PORTS
//  clk          in   1   single clock; all state updates on posedge clk
//  rst_n        in   1   synchronous, active-low reset
//  start        in   1   leave IDLE and begin fetching at pc=0
//  instruction  in   32  word registered by instruction memory; valid from DECODE onward
//  alu_eq       in   1   datapath flag rs==rt, valid during EXEC
//  state        out  3   current FSM state (encoding below)
//  pc           out  4   current instruction address
//  reg_write    out  1   register-file write enable (WB only)
//  mem_read     out  1   data-memory read (MEM, lw only)
//  alu_src_imm  out  1   ALU operand B = sign-extended imm16 (lw, addiu)
//  alu_op       out  2   00 add, 01 slt, 10 compare (branch)
//  reg_dst_rd   out  1   write dest = rd[15:11] (R-type), else rt[20:16]
//  done         out  1   sticky; program finished normally
//  illegal      out  1   sticky; unsupported opcode/funct hit
// BEHAVIOUR
//  - Encodings: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 IDLE=6; 7 unused -> treated as HALT.
//  - Reset (rst_n=0 at posedge): state=IDLE, pc=0, done=0, illegal=0; all strobes 0. Reset mid-instruction aborts it, no write.
//  - IDLE: stay until start=1, then FETCH. start ignored in every other state.
//  - FETCH -> DECODE always (1 cycle; memory latches instruction[pc]).
//  - DECODE: opcode[31:26]: 100011 lw, 001001 addiu, 000100 beq, 000101 bne -> EXEC;
//    000000 with funct[5:0] 100001 addu or 101010 slt -> EXEC; anything else -> HALT, illegal<=1.
//  - EXEC: lw -> MEM; addiu/R-type -> WB; beq/bne -> resolve (below) then FETCH or HALT.
//  - MEM -> WB. WB: reg_write=1 for one cycle, then PC update.
//  - Cycle counts: lw 5, addiu/addu/slt 4, beq/bne 3 (FETCH to next FETCH).
//  - PC update (at end of WB or branch EXEC): next = pc+1, or for taken branch (beq&alu_eq | bne&!alu_eq)
//    next = pc+1+sext(imm16), computed in 18-bit signed. If next<0 or next>=PROG_LEN: pc unchanged,
//    state->HALT, done<=1. Else pc<=next[3:0], state->FETCH.
//  - Strobes are Moore-style: function of state register and decoded instruction; 0 in IDLE/HALT/FETCH/DECODE.
//    alu_op/alu_src_imm/reg_dst_rd held stable EXEC through WB.
//  - HALT: absorbing; only rst_n leaves it. done and illegal never both 1.
// STRUCTURE
//  - mc_pkg: state localparams, opcode/funct constants, alu_op codes, PROG_LEN default.
//  - Sub-module mc_decoder (combinational): instruction -> {is_lw,is_addiu,is_rtype,is_beq,is_bne,legal,imm16}.
//  - Top: state register, pc register, next-pc adder/range check, strobe decode.
// TESTING
//  - Reset/idle: rst_n=0 two cycles then 1, start=0 for 5 cycles -> state=6, pc=0, all strobes 0.
//  - Full program (11-word test ROM, lw x3/addiu x2/slt-loop) with start pulse -> lw spends 5 cycles,
//    addu 4; final beq at pc=6 (offset 5 -> 12) taken -> HALT, done=1, pc=6.
//  - bne at pc=10, imm=-3, alu_eq=0 -> pc=8 after 3 cycles; alu_eq=1 -> next=11=PROG_LEN -> HALT, done=1.
//  - Illegal: instruction=32'hFC000000 at DECODE -> HALT next cycle, illegal=1, reg_write never asserted.
//  - Reset mid-lw (rst_n=0 in MEM) -> next cycle state=6, pc=0, reg_write=0, done=0.
//  - Negative target: beq at pc=1, imm=-5, alu_eq=1 -> HALT, done=1, pc=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Purpose: shared state encodings, opcode/funct constants and ALU op codes for the multicycle sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_pkg;

  // FSM state encoding as seen on the external state bus (FETCH must be 0).
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_IDLE   = 3'd6
  } state_e;

  // Primary opcodes, instruction[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // R-type function codes, instruction[5:0].
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // ALU operation selects.
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SLT  = 2'b01;
  localparam logic [1:0] ALU_CMP  = 2'b10;

  // Default program geometry.
  localparam int PROG_LEN_DEF = 11;
  localparam int PC_W_DEF     = 4;

endpackage

// File: rtl/mc_decoder.sv
// Purpose: combinational instruction classifier for the supported MIPS subset.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
module mc_decoder
  import mc_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        is_lw,
  output logic        is_addiu,
  output logic        is_rtype,
  output logic        is_slt,
  output logic        is_beq,
  output logic        is_bne,
  output logic        legal,
  output logic [15:0] imm16
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign imm16  = instruction[15:0];

  // Register specifiers are consumed by the datapath, not by the sequencer.
  assign unused_fields = ^instruction[25:16];

  // Classify the opcode; an R-type word is only recognised with a supported funct.
  always_comb begin
    is_lw    = (opcode == OP_LW);
    is_addiu = (opcode == OP_ADDIU);
    is_beq   = (opcode == OP_BEQ);
    is_bne   = (opcode == OP_BNE);
    is_rtype = (opcode == OP_RTYPE) && ((funct == FN_ADDU) || (funct == FN_SLT));
    is_slt   = (opcode == OP_RTYPE) && (funct == FN_SLT);
    legal    = is_lw | is_addiu | is_beq | is_bne | is_rtype;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multicycle sequencer: state bus, PC ownership, branch resolution and per-state datapath strobes.
// Latency: lw 5 cycles, addiu/addu/slt 4, beq/bne 3 (FETCH to next FETCH).
// Backpressure: none; start is honoured only in IDLE, HALT is left only through rst_n.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int PROG_LEN = PROG_LEN_DEF,
  parameter int PC_W     = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     instruction,
  input  logic            alu_eq,
  output logic [2:0]      state,
  output logic [PC_W-1:0] pc,
  output logic            reg_write,
  output logic            mem_read,
  output logic            alu_src_imm,
  output logic [1:0]      alu_op,
  output logic            reg_dst_rd,
  output logic            done,
  output logic            illegal
);

  localparam logic signed [17:0] PROG_LEN_S = 18'(PROG_LEN);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;

  logic            is_lw, is_addiu, is_rtype, is_slt, is_beq, is_bne, legal;
  logic [15:0]     imm16;

  logic            taken;
  logic signed [17:0] next_pc;
  logic            next_ok;
  logic            in_exec_to_wb;

  mc_decoder u_dec (
    .instruction (instruction),
    .is_lw       (is_lw),
    .is_addiu    (is_addiu),
    .is_rtype    (is_rtype),
    .is_slt      (is_slt),
    .is_beq      (is_beq),
    .is_bne      (is_bne),
    .legal       (legal),
    .imm16       (imm16)
  );

  // Next PC: sequential by default, pc+1+sext(imm16) for a taken branch, checked in 18-bit signed.
  always_comb begin
    taken   = (state_q == ST_EXEC) && ((is_beq && alu_eq) || (is_bne && !alu_eq));
    next_pc = $signed({{(18-PC_W){1'b0}}, pc_q}) + 18'sd1;
    if (taken) begin
      next_pc = next_pc + $signed({{2{imm16[15]}}, imm16});
    end
    next_ok = (next_pc >= 18'sd0) && (next_pc < PROG_LEN_S);
  end

  // Next-state, PC and sticky status flags.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    done_d    = done_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (is_lw) begin
          state_d = ST_MEM;
        end else if (is_beq || is_bne) begin
          if (next_ok) begin
            pc_d    = next_pc[PC_W-1:0];
            state_d = ST_FETCH;
          end else begin
            state_d = ST_HALT;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        if (next_ok) begin
          pc_d    = next_pc[PC_W-1:0];
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
          done_d  = 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State, PC and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore-style strobes: operand/op selects held constant from EXEC through WB.
  always_comb begin
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    alu_src_imm   = 1'b0;
    alu_op        = ALU_ADD;
    reg_dst_rd    = 1'b0;
    in_exec_to_wb = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);
    if (in_exec_to_wb) begin
      alu_src_imm = is_lw | is_addiu;
      reg_dst_rd  = is_rtype;
      if (is_beq || is_bne) begin
        alu_op = ALU_CMP;
      end else if (is_slt) begin
        alu_op = ALU_SLT;
      end
    end
    if (state_q == ST_MEM) begin
      mem_read = is_lw;
    end
    if (state_q == ST_WB) begin
      reg_write = 1'b1;
    end
  end

  assign state   = state_q;
  assign pc      = pc_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule
